// File: rtl/custom_axi_result_buffer.sv
// -----------------------------------------------------------------------------
// custom_axi_ip_pkg
//   Shared type for the custom AXI IP core status output.
//
// custom_axi_result_buffer
//   Captures result words pushed by the custom AXI IP core into a DEPTH-entry
//   circular FIFO. Software pops one word at a time via the register read path.
//   Overflow, underflow and observed ERROR status are held as sticky flags. A
//   level interrupt is raised while occupancy is at or above IRQ_THRESH.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   wen_i        push strobe, one word per high cycle
//   wdata_i      word to push
//   status_i     core status, ERROR sets err_seen_o
//   rd_req_i     pop request pulse
//   clr_i        flush FIFO and clear sticky flags
//   rd_data_o    popped word, valid while rd_valid_o=1
//   rd_valid_o   pulse, the cycle after an accepted pop
//   count_o      occupancy 0..DEPTH
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
//   overflow_o   sticky: push rejected because the FIFO was full
//   underflow_o  sticky: pop requested while empty
//   err_seen_o   sticky: status_i == ERROR seen
//   irq_o        count_o >= IRQ_THRESH
// -----------------------------------------------------------------------------
package custom_axi_ip_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;
endpackage

module custom_axi_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int IRQ_THRESH = 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wen_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  custom_axi_ip_pkg::status_e status_i,
    input  logic                       rd_req_i,
    input  logic                       clr_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic                       rd_valid_o,
    output logic [CW-1:0]              count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    output logic                       err_seen_o,
    output logic                       irq_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_err_seen;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_err;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // Pop looks only at the pre-edge count, so an empty FIFO never bypasses a
    // same-cycle push to the reader. A full FIFO may accept a push when a pop
    // frees a slot on the same edge.
    assign w_pop   = rd_req_i && !w_empty;
    assign w_push  = wen_i && (!w_full || w_pop);
    assign w_err   = (status_i == custom_axi_ip_pkg::ERROR);

    // NOTE: storage carries no reset; pointers and count define which entries
    // are meaningful, so resetting the array would only cost flops and fanout.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clr_i && w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_err_seen  <= 1'b0;
        end else if (clr_i) begin
            // Flush ignores same-cycle push/pop/status; rd_data keeps its value.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_err_seen  <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            if (wen_i && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (rd_req_i && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_err) begin
                r_err_seen <= 1'b1;
            end
        end
    end

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign count_o     = r_count;
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
    assign err_seen_o  = r_err_seen;
    assign irq_o       = (r_count >= CW'(IRQ_THRESH));

endmodule
